// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding the register-file write port.
// Merges memory-stage and ALU-stage requests (memory first when both arrive),
// drains at most one entry per cycle into a registered write port, and reports
// pending writes to two query registers so decode can stall on RAW hazards.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  input  logic [AW-1:0]                m_reg,
  input  logic [DW-1:0]                m_data,
  output logic                         m_ready,
  input  logic                         a_valid,
  input  logic [AW-1:0]                a_reg,
  input  logic [DW-1:0]                a_data,
  output logic                         a_ready,
  input  logic                         stall,
  output logic                         write,
  output logic [AW-1:0]                writeregsel,
  output logic [DW-1:0]                writedata,
  input  logic [AW-1:0]                chk1regsel,
  input  logic [AW-1:0]                chk2regsel,
  output logic                         chk1pend,
  output logic                         chk2pend,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] q_reg  [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr_a;
  logic          m_acc, a_acc, pop;

  // Previous-cycle snapshot of each stalled request for the stability check.
  logic          m_wait, a_wait;
  logic [AW-1:0] m_reg_q, a_reg_q;
  logic [DW-1:0] m_data_q, a_data_q;
  logic          m_viol, a_viol;

  // Distance of slot i from the head, modulo DEPTH.
  function automatic logic [PW-1:0] slot_off(input int i, input logic [PW-1:0] rp);
    logic [PW-1:0] s;
    s = PW'(i);
    return s - rp;
  endfunction

  // Space is judged on the pre-edge count only, so ready never depends on stall.
  assign m_ready  = (count < FULL);
  assign a_ready  = m_valid ? (count < FULL - CW'(1)) : (count < FULL);
  assign m_acc    = m_valid & m_ready;
  assign a_acc    = a_valid & a_ready;
  assign pop      = (count != '0) & ~stall;
  assign wr_ptr_a = wr_ptr + PW'(m_acc);

  assign m_viol = m_wait & (~m_valid | (m_reg != m_reg_q) | (m_data != m_data_q));
  assign a_viol = a_wait & (~a_valid | (a_reg != a_reg_q) | (a_data != a_data_q));

  // Queue storage: memory entry lands first, ALU entry right behind it.
  always_ff @(posedge clk) begin
    if (m_acc) begin
      q_reg[wr_ptr]  <= m_reg;
      q_data[wr_ptr] <= m_data;
    end
    if (a_acc) begin
      q_reg[wr_ptr_a]  <= a_reg;
      q_data[wr_ptr_a] <= a_data;
    end
  end

  // Pointers, occupancy, registered write port and sticky protocol error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      write       <= 1'b0;
      writeregsel <= '0;
      writedata   <= '0;
      err         <= 1'b0;
      m_wait      <= 1'b0;
      a_wait      <= 1'b0;
      m_reg_q     <= '0;
      a_reg_q     <= '0;
      m_data_q    <= '0;
      a_data_q    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(m_acc) + PW'(a_acc);
      count  <= count + CW'(m_acc) + CW'(a_acc) - CW'(pop);
      write  <= pop;
      if (pop) begin
        writeregsel <= q_reg[rd_ptr];
        writedata   <= q_data[rd_ptr];
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (m_viol | a_viol) err <= 1'b1;
      m_wait   <= m_valid & ~m_ready;
      a_wait   <= a_valid & ~a_ready;
      m_reg_q  <= m_reg;
      a_reg_q  <= a_reg;
      m_data_q <= m_data;
      a_data_q <= a_data;
    end
  end

  // Hazard flags: any live queue slot or the in-flight write targeting the register.
  always_comb begin
    chk1pend = write & (writeregsel == chk1regsel);
    chk2pend = write & (writeregsel == chk2regsel);
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, slot_off(i, rd_ptr)} < count) begin
        if (q_reg[i] == chk1regsel) chk1pend = 1'b1;
        if (q_reg[i] == chk2regsel) chk2pend = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_valid = 1'b0, a_valid = 1'b0, stall = 1'b0;
  logic [2:0]  m_reg = '0, a_reg = '0, chk1regsel = '0, chk2regsel = '0;
  logic [15:0] m_data = '0, a_data = '0;
  logic        m_ready, a_ready, write, chk1pend, chk2pend, err;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [18:0] exp_q[$];

  rf_writeback_queue #(.DEPTH(4), .DW(16), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data), .m_ready(m_ready),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .stall(stall), .write(write), .writeregsel(writeregsel), .writedata(writedata),
    .chk1regsel(chk1regsel), .chk2regsel(chk2regsel),
    .chk1pend(chk1pend), .chk2pend(chk2pend), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [2:0] r, input logic [15:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (count == 3'd0 && write == 1'b0) done = 1'b1;
    end
    check("drain_done", {31'd0, done}, 32'd1);
  endtask

  // Monitor: every cycle with write=1 must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {13'd0, writeregsel, writedata}, 32'd0);
        if (writeregsel == 3'd0 && writedata == 16'd0) begin
          fails++;
          $display("FAIL unexpected_write: got write with empty scoreboard expected none");
        end
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("write_port", {13'd0, writeregsel, writedata}, {13'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    #12;
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_m_ready", {31'd0, m_ready}, 32'd1);
    check("rst_a_ready", {31'd0, a_ready}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_chk1pend", {31'd0, chk1pend}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // 2: single ALU write, latency and pulse width
    chk1regsel = 3'd3;
    a_valid = 1'b1; a_reg = 3'd3; a_data = 16'h1234;
    @(negedge clk);
    check("t2_a_ready", {31'd0, a_ready}, 32'd1);
    step();
    expect_wr(3'd3, 16'h1234);
    a_valid = 1'b0;
    @(negedge clk);
    check("t2_write_early", {31'd0, write}, 32'd0);
    check("t2_pend_queued", {31'd0, chk1pend}, 32'd1);
    step();
    @(negedge clk);
    check("t2_write_pulse", {31'd0, write}, 32'd1);
    step();
    @(negedge clk);
    check("t2_write_end", {31'd0, write}, 32'd0);
    check("t2_pend_clear", {31'd0, chk1pend}, 32'd0);

    // 3: same-cycle m and a to R1, ordering and hazard lifetime
    chk1regsel = 3'd1;
    m_valid = 1'b1; m_reg = 3'd1; m_data = 16'hAAAA;
    a_valid = 1'b1; a_reg = 3'd1; a_data = 16'hBBBB;
    step();
    expect_wr(3'd1, 16'hAAAA);
    expect_wr(3'd1, 16'hBBBB);
    m_valid = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    check("t3_pend_q", {31'd0, chk1pend}, 32'd1);
    check("t3_count2", {29'd0, count}, 32'd2);
    step();
    @(negedge clk);
    check("t3_wr1", {31'd0, write}, 32'd1);
    check("t3_pend_w1", {31'd0, chk1pend}, 32'd1);
    step();
    @(negedge clk);
    check("t3_wr2", {31'd0, write}, 32'd1);
    check("t3_pend_w2", {31'd0, chk1pend}, 32'd1);
    step();
    @(negedge clk);
    check("t3_wr_done", {31'd0, write}, 32'd0);
    check("t3_pend_done", {31'd0, chk1pend}, 32'd0);

    // 4: fill under stall, partial acceptance at count=3, then drain
    stall = 1'b1;
    m_valid = 1'b1; m_reg = 3'd2; m_data = 16'h2222;
    a_valid = 1'b1; a_reg = 3'd4; a_data = 16'h4444;
    step();
    expect_wr(3'd2, 16'h2222);
    expect_wr(3'd4, 16'h4444);
    m_valid = 1'b0;
    a_reg = 3'd5; a_data = 16'h5555;
    step();
    expect_wr(3'd5, 16'h5555);
    m_valid = 1'b1; m_reg = 3'd6; m_data = 16'h6666;
    a_reg = 3'd7; a_data = 16'h7777;
    @(negedge clk);
    check("t4_count3", {29'd0, count}, 32'd3);
    check("t4_m_ready3", {31'd0, m_ready}, 32'd1);
    check("t4_a_ready3", {31'd0, a_ready}, 32'd0);
    step();
    expect_wr(3'd6, 16'h6666);
    m_valid = 1'b0;
    chk1regsel = 3'd5; chk2regsel = 3'd3;
    @(negedge clk);
    check("t4_count4", {29'd0, count}, 32'd4);
    check("t4_m_ready4", {31'd0, m_ready}, 32'd0);
    check("t4_a_ready4", {31'd0, a_ready}, 32'd0);
    check("t4_stalled", {31'd0, write}, 32'd0);
    check("t4_chk1pend", {31'd0, chk1pend}, 32'd1);
    check("t4_chk2pend", {31'd0, chk2pend}, 32'd0);
    stall = 1'b0;
    step();
    @(negedge clk);
    check("t4_a_ready_after_pop", {31'd0, a_ready}, 32'd1);
    check("t4_count_after_pop", {29'd0, count}, 32'd3);
    step();
    expect_wr(3'd7, 16'h7777);
    a_valid = 1'b0;
    drain(20);
    check("t4_err", {31'd0, err}, 32'd0);

    // 5: ALU valid drops while not ready -> sticky err
    stall = 1'b1;
    m_valid = 1'b1; m_reg = 3'd1; m_data = 16'h0101;
    a_valid = 1'b1; a_reg = 3'd2; a_data = 16'h0202;
    step();
    m_reg = 3'd3; m_data = 16'h0303;
    a_reg = 3'd4; a_data = 16'h0404;
    step();
    expect_wr(3'd1, 16'h0101); expect_wr(3'd2, 16'h0202);
    expect_wr(3'd3, 16'h0303); expect_wr(3'd4, 16'h0404);
    m_valid = 1'b0;
    a_reg = 3'd5; a_data = 16'h0505;
    @(negedge clk);
    check("t5_a_ready", {31'd0, a_ready}, 32'd0);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    check("t5_err_before", {31'd0, err}, 32'd0);
    step();
    @(negedge clk);
    check("t5_err_set", {31'd0, err}, 32'd1);
    stall = 1'b0;
    drain(20);
    check("t5_err_sticky", {31'd0, err}, 32'd1);

    // 6: reset mid-drain drops the queue
    stall = 1'b1;
    m_valid = 1'b1; m_reg = 3'd1; m_data = 16'h1111;
    a_valid = 1'b1; a_reg = 3'd2; a_data = 16'h2222;
    step();
    m_reg = 3'd3; m_data = 16'h3333;
    a_reg = 3'd4; a_data = 16'h4444;
    step();
    m_valid = 1'b0; a_valid = 1'b0;
    expect_wr(3'd1, 16'h1111);
    stall = 1'b0;
    step();
    @(negedge clk);
    check("t6_count3", {29'd0, count}, 32'd3);
    check("t6_write", {31'd0, write}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_write", {31'd0, write}, 32'd0);
    check("t6_rst_count", {29'd0, count}, 32'd0);
    step();
    step();
    rst = 1'b1;
    repeat (10) step();
    check("t6_count_after", {29'd0, count}, 32'd0);
    check("t6_write_after", {31'd0, write}, 32'd0);
    check("t6_err_cleared", {31'd0, err}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
